// File: rtl/mdu_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : mdu_ctrl
// Description : Multi-cycle multiply/divide unit with sequencing controller and
//               architectural HI/LO registers; holds Busy for a fixed latency.
// Revision    : 1.0 - initial release
//==============================================================================
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       op_q, op_next;
    logic [31:0]      a_q, a_next;
    logic [31:0]      b_q, b_next;
    logic [31:0]      hi_q, hi_next;
    logic [31:0]      lo_q, lo_next;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_signed;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quo_u;
    logic [31:0] rem_u;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic        start_md;

    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // One unsigned divider serves both div and divu; signed division works on
    // magnitudes so 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
    assign div_signed = (op_q == OP_DIV);
    assign a_mag      = a_q[31] ? (32'd0 - a_q) : a_q;
    assign b_mag      = b_q[31] ? (32'd0 - b_q) : b_q;
    assign dividend   = div_signed ? a_mag : a_q;
    assign divisor    = (b_q == 32'd0) ? 32'd1 : (div_signed ? b_mag : b_q);
    assign quo_u      = dividend / divisor;
    assign rem_u      = dividend % divisor;
    assign quo_s      = (a_q[31] ^ b_q[31]) ? (32'd0 - quo_u) : quo_u;
    assign rem_s      = a_q[31] ? (32'd0 - rem_u) : rem_u;

    assign start_md = Start && (MDUOp inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        op_next    = op_q;
        a_next     = a_q;
        b_next     = b_q;
        hi_next    = hi_q;
        lo_next    = lo_q;
        case (state)
            IDLE: begin
                if (start_md) begin
                    op_next    = MDUOp;
                    a_next     = A;
                    b_next     = B;
                    state_next = RUN;
                    cnt_next   = (MDUOp inside {OP_MULT, OP_MULTU}) ? CNT_W'(MULT_CYCLES)
                                                                    : CNT_W'(DIV_CYCLES);
                end else if (Start && MDUOp == OP_MTHI) begin
                    hi_next = A;
                end else if (Start && MDUOp == OP_MTLO) begin
                    lo_next = A;
                end
            end
            RUN: begin
                cnt_next = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_next = IDLE;
                    case (op_q)
                        OP_MULT:  {hi_next, lo_next} = prod_s;
                        OP_MULTU: {hi_next, lo_next} = prod_u;
                        OP_DIV: begin
                            if (b_q != 32'd0) begin
                                hi_next = rem_s;
                                lo_next = quo_s;
                            end
                        end
                        OP_DIVU: begin
                            if (b_q != 32'd0) begin
                                hi_next = rem_u;
                                lo_next = quo_u;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            op_q  <= op_next;
            a_q   <= a_next;
            b_q   <= b_next;
            hi_q  <= hi_next;
            lo_q  <= lo_next;
        end
    end

    assign Busy  = (state == RUN);
    assign Stall = Busy | start_md;
    assign HI    = hi_q;
    assign LO    = lo_q;

endmodule
`default_nettype wire

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit with its sequencing controller and the architectural HI/LO registers.
- Sits in the EX stage beside the ALU.
- Accepts one operation per Start pulse and holds Busy for a fixed latency.
- Commits the results to HI/LO in a single write. The hazard unit uses Stall to freeze the pipeline front-end while an operation is in flight.

Parameters:
- MULT_CYCLES, 5: cycles Busy stays high for mult/multu; legal range ≥1.
- DIV_CYCLES, 10: cycles Busy stays high for div/divu; legal range ≥1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Start  input  1  request strobe; sampled on the rising edge.
- MDUOp  input  3  operation code, valid when Start=1:
  - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo.
  - 7 is reserved and treated as none.
- A  input  32  operand rs; dividend; source for mthi/mtlo.
- B  input  32  operand rt; divisor.
- Busy  output  1  registered; high while an operation is in flight.
- Stall  output  1  combinational: Busy | (Start & MDUOp in 1..4).
- HI  output  32  registered HI register.
- LO  output  32  registered LO register.

Behaviour:

Reset
- When reset=1 at an edge: Busy=0, HI=0, LO=0, cycle counter=0, latched operands/op cleared.
- Reset overrides Start and any in-flight operation; the pending result is discarded and never written.

States
- IDLE (Busy=0) and RUN (Busy=1). The state is Busy itself plus a down-counter cnt, sized for max(MULT_CYCLES, DIV_CYCLES).

IDLE transitions
- Start=1 and MDUOp in 1..4:
  - latch A, B and MDUOp;
  - cnt <= MULT_CYCLES (ops 1–2) or DIV_CYCLES (ops 3–4);
  - Busy <= 1.
- Start=1 and MDUOp=5: HI <= A at this edge; stay IDLE.
- Start=1 and MDUOp=6: LO <= A at this edge; stay IDLE.
- Start=1 with MDUOp 0 or 7, or Start=0: no change.

RUN transitions
- Each edge: cnt <= cnt-1.
- At the edge where cnt==1: write HI/LO from the latched operands, Busy <= 0, return to IDLE.
- Busy is therefore high for exactly N cycles, and new HI/LO are visible in the first cycle Busy reads 0.
- Start while Busy=1, any MDUOp including mthi/mtlo, is ignored: no state change and no queueing. The pipeline is required to be stalled then; the bench checks that the ignore happens.
- Latched operands are used, so A/B changes during RUN have no effect.

Arithmetic
- mult: 64-bit two's-complement signed product; HI = [63:32], LO = [31:0].
- multu: unsigned 64-bit product, same split.
- div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
- div special case: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient in LO, remainder in HI.
- Divisor 0 (div or divu): the full latency still runs and Busy behaves normally, but HI and LO are left unchanged at commit.
- Result computation may be combinational on the latched operands or iterative; only the commit timing is architectural.

Back-to-back operation
- Start accepted in the same cycle Busy drops to 0 (IDLE at that edge) starts a new operation on the next edge without a gap.
- An mthi/mtlo issued in that cycle writes at that edge, after the previous commit.

Stall
- Purely combinational.
- Asserts in the Start cycle of a mult/div so the following instruction never samples stale HI/LO.

Test Plan:
- reset, then Start mult with A=0xFFFFFFFE (-2), B=3 → Busy high exactly 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA once Busy falls; Stall=1 in the Start cycle.
- Start multu with A=0xFFFFFFFF, B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001 after 5 cycles.
- Start div with A=-7 (0xFFFFFFF9), B=2 → Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu A=7, B=0 → HI/LO unchanged after 10 cycles.
- Start div with A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- mthi A=0x12345678, then mtlo A=0x9ABCDEF0 on consecutive cycles → HI/LO update at the respective edges. During a running mult, issue mthi and a second mult with changed A/B → both ignored; the first result commits unchanged.
- Start mult, assert reset in cycle 3 of RUN → next edge Busy=0, HI=LO=0; no later commit occurs.
